// File: rtl/nibble_serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder_pkg
// Brief    : Shared nibble width and FSM state encodings for the serial adder.
// Revision : 1.0
// ============================================================================
package nibble_serial_adder_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/carrySellectAdder.sv
`default_nettype none
// ============================================================================
// Module   : carrySellectAdder
// Brief    : 4-bit carry-select adder; upper half precomputed for both carries.
// Revision : 1.0
// ============================================================================
module carrySellectAdder (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic [2:0] w_lo;
   logic [2:0] w_hi0;
   logic [2:0] w_hi1;

   assign w_lo  = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, cin};
   assign w_hi0 = {1'b0, a[3:2]} + {1'b0, b[3:2]};
   assign w_hi1 = w_hi0 + 3'd1;

   // Lower-half carry picks which precomputed upper half is used
   assign sum  = {(w_lo[2] ? w_hi1[1:0] : w_hi0[1:0]), w_lo[1:0]};
   assign cout = w_lo[2] ? w_hi1[2] : w_hi0[2];

endmodule
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder
// Brief    : WIDTH-bit adder that feeds one 4-bit adder a nibble per cycle.
// Revision : 1.0
// ============================================================================
module nibble_serial_adder
   import nibble_serial_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int NUM_NIB = WIDTH / NIB_W;
   localparam int CNT_W   = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NUM_NIB - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH-1:0]   r_a_sh;
   logic [WIDTH-1:0]   r_b_sh;
   logic [WIDTH-1:0]   r_sum_sh;
   logic [WIDTH-1:0]   w_sum_sh_nxt;
   logic               r_carry;
   logic [CNT_W-1:0]   r_cnt;
   logic [NIB_W-1:0]   w_nib_sum;
   logic               w_nib_cout;

   carrySellectAdder u_csa (
      .a    (r_a_sh[NIB_W-1:0]),
      .b    (r_b_sh[NIB_W-1:0]),
      .cin  (r_carry),
      .sum  (w_nib_sum),
      .cout (w_nib_cout)
   );

   generate
      if (NUM_NIB == 1) begin : g_single
         assign w_sum_sh_nxt = w_nib_sum;
      end else begin : g_multi
         assign w_sum_sh_nxt = {w_nib_sum, r_sum_sh[WIDTH-1:NIB_W]};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (in_valid)         w_state_nxt = RUN;
         RUN:     if (r_cnt == C_LAST)  w_state_nxt = DONE;
         DONE:    if (out_ready)        w_state_nxt = IDLE;
         default:                       w_state_nxt = IDLE;
      endcase
   end

   // sum_sh and carry_q double as the result registers held through DONE and IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_sum_sh <= '0;
         r_carry  <= 1'b0;
         r_cnt    <= '0;
      end else if (r_state == IDLE && in_valid) begin
         r_a_sh  <= a;
         r_b_sh  <= b;
         r_carry <= cin;
         r_cnt   <= '0;
      end else if (r_state == RUN) begin
         r_sum_sh <= w_sum_sh_nxt;
         r_a_sh   <= r_a_sh >> NIB_W;
         r_b_sh   <= r_b_sh >> NIB_W;
         r_carry  <= w_nib_cout;
         r_cnt    <= r_cnt + CNT_W'(1);
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign busy      = (r_state == RUN) || (r_state == DONE);
   assign sum       = r_sum_sh;
   assign cout      = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_adder
// Brief    : Scoreboard bench for nibble_serial_adder at WIDTH 16, 4 and 32.
// Revision : 1.0
// ============================================================================
module tb_nibble_serial_adder;

   localparam int W = 16;
   localparam int N = W / 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
   logic [W-1:0] a, b, sum;

   logic         in_valid4, in_ready4, cin4, out_valid4, cout4, busy4;
   logic [3:0]   a4, b4, sum4;
   logic         in_valid32, in_ready32, cin32, out_valid32, cout32, busy32;
   logic [31:0]  a32, b32, sum32;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int last_hs  = -1;
   bit b2b      = 1'b0;
   logic [W:0] sb_q[$];

   nibble_serial_adder #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .busy(busy)
   );

   nibble_serial_adder #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
      .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(1'b1),
      .sum(sum4), .cout(cout4), .busy(busy4)
   );

   nibble_serial_adder #(.WIDTH(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
      .a(a32), .b(b32), .cin(cin32), .out_valid(out_valid32), .out_ready(1'b1),
      .sum(sum32), .cout(cout32), .busy(busy32)
   );

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout required=handshake", name);
   endtask

   // Monitor: every output handshake pops the oldest expected result
   always @(negedge clk) begin
      logic [W:0] e;
      if (rst_n && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result actual=%0h required=none", {cout, sum});
         end else begin
            e = sb_q.pop_front();
            chk("result", {47'd0, cout, sum}, {47'd0, e});
         end
         if (b2b && last_hs >= 0) chk("spacing", 64'(cyc - last_hs), 64'(N + 2));
         last_hs = cyc;
      end
   end

   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                       input logic [W:0] exp, input bit push);
      int n = 0;
      a = ta; b = tb; cin = tc; in_valid = 1'b1;
      while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
      if (!in_ready) begin
         timeout("accept");
         in_valid = 1'b0;
         return;
      end
      if (push) sb_q.push_back(exp);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((sb_q.size() != 0 || !in_ready) && n < 200) begin @(posedge clk); #1; n++; end
      if (sb_q.size() != 0 || !in_ready) timeout("drain");
   endtask

   task automatic run32(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                        input logic [32:0] exp);
      int n = 0;
      a32 = ta; b32 = tb; cin32 = tc; in_valid32 = 1'b1;
      while (!in_ready32 && n < 50) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      in_valid32 = 1'b0;
      n = 0;
      while (!out_valid32 && n < 50) begin @(posedge clk); #1; n++; end
      if (!out_valid32) timeout("w32");
      else chk("w32", {31'd0, cout32, sum32}, {31'd0, exp});
      @(posedge clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] ra, rb;
      logic         rc;
      logic [31:0]  r32a, r32b;
      int           n;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
      in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
      in_valid32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset", {in_ready, out_valid, busy, cout, sum}, {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Latency and back-pressure
      send(16'h1234, 16'h4321, 1'b0, 17'h05555, 1'b1);
      repeat (3) begin @(posedge clk); #1; end
      chk("lat_pre", {63'd0, out_valid}, 64'd0);
      @(posedge clk); #1;
      chk("lat", {out_valid, busy}, 2'b11);
      for (int i = 0; i < 5; i++) begin
         chk("backpressure", {out_valid, in_ready, cout, sum}, {1'b1, 1'b0, 1'b0, 16'h5555});
         if (i == 2) begin in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; end
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("post_hs", {out_valid, in_ready, sum}, {1'b0, 1'b1, 16'h5555});

      // Asynchronous reset during RUN with cnt==2
      send(16'hABCD, 16'h1111, 1'b0, 17'h0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk("reset_mid", {out_valid, in_ready, busy, cout, sum}, {1'b0, 1'b1, 1'b0, 1'b0, 16'h0000});
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      send(16'h0001, 16'h0001, 1'b0, 17'h00002, 1'b1); drain();
      send(16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1'b1); drain();
      send(16'hFFFF, 16'h0000, 1'b1, 17'h10000, 1'b1); drain();
      send(16'h8000, 16'h8000, 1'b0, 17'h10000, 1'b1); drain();
      send(16'h0F0F, 16'h00F1, 1'b0, 17'h01000, 1'b1); drain();

      // Back-to-back throughput
      last_hs = -1;
      b2b = 1'b1;
      for (int i = 0; i < 20; i++) begin
         ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
         send(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {16'd0, rc}, 1'b1);
      end
      drain();
      b2b = 1'b0;

      // Single-nibble instance
      a4 = 4'hF; b4 = 4'h1; cin4 = 1'b1; in_valid4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      n = 0;
      while (!out_valid4 && n < 20) begin @(posedge clk); #1; n++; end
      if (!out_valid4) timeout("w4");
      else chk("w4", {59'd0, cout4, sum4}, {59'd0, 5'h11});
      @(posedge clk); #1;

      // 32-bit instance
      run32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33'h1_0000_0000);
      run32(32'h89AB_CDEF, 32'h1234_5678, 1'b0, 33'h0_9BE0_2467);
      r32a = $urandom; r32b = $urandom;
      run32(r32a, r32b, 1'b1, {1'b0, r32a} + {1'b0, r32b} + 33'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
